// File: rtl/sound_delay.sv
// rtl/sound_delay.sv - single-channel spatial delay stage with distance attenuation
//
// Once per audio sample the incoming sample is written into a circular buffer.
// The sample from D strobes earlier is selected, where D = distance + itd(theta).
// It is then arithmetically shifted right by distance[7:6] and registered.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   rst_n      asynchronous active-low reset
//   theta      source angle, 0..255 maps to 0..360 degrees
//   distance   source distance in sample-delay units
//   signal_in  signed PCM sample, held stable between strobes
//   signal_out signed delayed and attenuated sample

module sound_delay #(
  parameter int CLK_DIV = 1134,
  parameter int DEPTH   = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  theta,
  input  logic [7:0]  distance,
  input  logic [15:0] signal_in,
  output logic [15:0] signal_out
);

  localparam int AW = $clog2(DEPTH);
  // fill must be able to hold DEPTH itself, hence one extra bit
  localparam int FW = AW + 1;
  localparam logic [10:0]   CNT_LAST = 11'(CLK_DIV - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [10:0]   cnt_q,        cnt_d;
  logic [AW-1:0] wp_q,         wp_d;
  logic [FW-1:0] fill_q,       fill_d;
  logic [15:0]   signal_out_q, signal_out_d;

  // Sample memory is deliberately not reset; fill_q guards against stale data.
  logic [15:0]   mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Sample strobe
  // ---------------------------------------------------------------------------
  logic stb;
  assign stb = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 11'd1;
    if (stb) begin
      cnt_d = 11'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay and gain from the controls
  // ---------------------------------------------------------------------------
  // Folding the angle about 180 degrees: 255 - theta is the bitwise inverse.
  logic [7:0] fold;
  logic [7:0] itd;
  logic [8:0] delay;
  logic [1:0] shift;

  assign fold  = theta[7] ? ~theta : theta;
  assign itd   = fold >> 2;
  assign delay = {1'b0, distance} + {1'b0, itd};
  assign shift = distance[7:6];

  // ---------------------------------------------------------------------------
  // Buffer read and sample selection
  // ---------------------------------------------------------------------------
  // The read happens combinationally from the current contents, so it sees the
  // buffer as it was before this strobe's write. D never exceeds 286, so the
  // read address can never equal the slot being written.
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [15:0]   sel;
  logic          not_filled;

  assign rd_addr    = wp_q - AW'(delay);
  assign rd_data    = mem_q[rd_addr];
  assign not_filled = (FW'(delay) > fill_q);

  always_comb begin
    sel = rd_data;
    if (delay == 9'd0) begin
      sel = signal_in;
    end else if (not_filled) begin
      sel = 16'd0;
    end
  end

  // Arithmetic shift keeps the sign and truncates toward minus infinity.
  logic signed [15:0] sel_s;
  logic signed [15:0] shifted;

  assign sel_s   = sel;
  assign shifted = sel_s >>> shift;

  // ---------------------------------------------------------------------------
  // Next-state for pointer, fill level and output
  // ---------------------------------------------------------------------------
  always_comb begin
    wp_d         = wp_q;
    fill_d       = fill_q;
    signal_out_d = signal_out_q;
    if (stb) begin
      wp_d         = wp_q + AW'(1);
      signal_out_d = shifted;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 11'd0;
      wp_q         <= '0;
      fill_q       <= '0;
      signal_out_q <= 16'd0;
    end else begin
      cnt_q        <= cnt_d;
      wp_q         <= wp_d;
      fill_q       <= fill_d;
      signal_out_q <= signal_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stb) begin
      mem_q[wp_q] <= signal_in;
    end
  end

  assign signal_out = signal_out_q;

endmodule

// File: tb/tb_sound_delay.sv
// tb/tb_sound_delay.sv - self-checking bench for sound_delay against a sample-history model

module tb_sound_delay;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  theta = 8'd0;
  logic [7:0]  distance = 8'd0;
  logic [15:0] signal_in = 16'd0;
  logic [15:0] signal_out;

  int checks = 0;
  int errors = 0;

  // Reference model: every sample written since reset, in order.
  logic [15:0] hist[$];
  int          n_wr = 0;
  logic [15:0] exp_out = 16'd0;

  sound_delay #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .theta     (theta),
    .distance  (distance),
    .signal_in (signal_in),
    .signal_out(signal_out)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    hist.delete();
    n_wr    = 0;
    exp_out = 16'd0;
  endtask

  // One strobe of the model: output is the input from D strobes ago, or zero
  // if fewer than D samples exist (buffer capped at DEPTH), or the input itself
  // when D is zero; then shifted right arithmetically by distance/64.
  task automatic model_step(input logic [15:0] s, input logic [7:0] th, input logic [7:0] di);
    int fold, d, fill, sh;
    logic signed [15:0] sel;
    fold = (th < 128) ? int'(th) : 255 - int'(th);
    d    = int'(di) + fold / 4;
    sh   = int'(di) / 64;
    fill = (n_wr < DEPTH) ? n_wr : DEPTH;
    if (d == 0)        sel = s;
    else if (d > fill) sel = 16'sd0;
    else               sel = hist[n_wr - d];
    hist.push_back(s);
    n_wr++;
    exp_out = sel >>> sh;
  endtask

  // Drives one full sample period starting right after a period boundary.
  // distance switches from di0 to di1 halfway through the period.
  // hold_obs: output just before the strobe edge; obs: output just after it.
  task automatic strobe(input logic [15:0] s, input logic [7:0] th, input logic [7:0] di0,
                        input logic [7:0] di1, output logic [15:0] hold_obs, output logic [15:0] obs);
    signal_in = s;
    theta     = th;
    distance  = di0;
    for (int i = 1; i < CLK_DIV; i++) begin
      @(posedge clk);
      #1;
      if (i == CLK_DIV / 2) distance = di1;
    end
    hold_obs = signal_out;
    @(posedge clk);
    #1;
    obs = signal_out;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [15:0] h, o, prev;
    #12;
    checks++;
    if (signal_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_value: got %h expected 0000", signal_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    // Bypass (D=0) so the first strobe edge is visible on the output.
    prev = exp_out;
    strobe(16'h1234, 8'hFF, 8'd0, 8'd0, h, o);
    model_step(16'h1234, 8'hFF, 8'd0);
    checks += 2;
    if (h !== prev) begin
      errors++;
      $display("FAIL first_strobe_early: got %h expected %h", h, prev);
    end
    if (o !== 16'h1234) begin
      errors++;
      $display("FAIL first_strobe: got %h expected 1234", o);
    end
  endtask

  task automatic test_basic();
    logic [15:0] h, o, prev, lit;
    reset_dut();
    for (int k = 0; k < 50; k++) begin
      prev = exp_out;
      strobe(16'(k + 1), 8'h00, 8'd7, 8'd7, h, o);
      model_step(16'(k + 1), 8'h00, 8'd7);
      lit = (k >= 7) ? 16'(k - 6) : 16'd0;
      checks += 3;
      if (h !== prev) begin
        errors++;
        $display("FAIL basic_hold k=%0d: got %h expected %h", k, h, prev);
      end
      if (o !== exp_out) begin
        errors++;
        $display("FAIL basic_model k=%0d: got %h expected %h", k, o, exp_out);
      end
      if (o !== lit) begin
        errors++;
        $display("FAIL basic_ramp k=%0d: got %h expected %h", k, o, lit);
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] h, o, prev, s;
    logic [7:0]  th;
    for (int k = 0; k < 90; k++) begin
      th = (k < 40) ? 8'h7F : (k < 80) ? 8'h80 : 8'hFF;
      s  = 16'($urandom);
      prev = exp_out;
      strobe(s, th, 8'd0, 8'd0, h, o);
      model_step(s, th, 8'd0);
      checks += 2;
      if (h !== prev) begin
        errors++;
        $display("FAIL bypass_hold k=%0d: got %h expected %h", k, h, prev);
      end
      if (o !== exp_out) begin
        errors++;
        $display("FAIL bypass_model k=%0d theta=%h: got %h expected %h", k, th, o, exp_out);
      end
      if (th == 8'hFF) begin
        checks++;
        if (o !== s) begin
          errors++;
          $display("FAIL bypass_direct k=%0d: got %h expected %h", k, o, s);
        end
      end
    end
  endtask

  task automatic test_attenuation();
    logic [15:0] h, o, lit;
    reset_dut();
    for (int k = 0; k < 200; k++) begin
      strobe(16'h8000, 8'h00, 8'hC0, 8'hC0, h, o);
      model_step(16'h8000, 8'h00, 8'hC0);
      lit = (k >= 192) ? 16'hF000 : 16'h0000;
      checks += 2;
      if (o !== exp_out) begin
        errors++;
        $display("FAIL atten_model k=%0d: got %h expected %h", k, o, exp_out);
      end
      if (o !== lit) begin
        errors++;
        $display("FAIL atten_value k=%0d: got %h expected %h", k, o, lit);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] h, o, prev, lit;
    reset_dut();
    for (int k = 0; k < 1100; k++) begin
      prev = exp_out;
      strobe(16'(k + 1), 8'h00, 8'd10, 8'd10, h, o);
      model_step(16'(k + 1), 8'h00, 8'd10);
      lit = (k >= 10) ? 16'(k - 9) : 16'd0;
      checks += 2;
      if (h !== prev) begin
        errors++;
        $display("FAIL wrap_hold k=%0d: got %h expected %h", k, h, prev);
      end
      if (o !== lit) begin
        errors++;
        $display("FAIL wrap_value k=%0d: got %h expected %h", k, o, lit);
      end
    end
  endtask

  task automatic test_control_change();
    logic [15:0] h, o, s;
    logic [7:0]  d0, d1;
    // Switch early (fill still below 20) and late (fill above 20).
    for (int pass = 0; pass < 2; pass++) begin
      reset_dut();
      for (int k = 0; k < 45; k++) begin
        int sw;
        sw = (pass == 0) ? 10 : 30;
        s  = 16'($urandom);
        d0 = (k <= sw) ? 8'd7 : 8'd20;
        d1 = (k < sw) ? 8'd7 : 8'd20;
        strobe(s, 8'h00, d0, d1, h, o);
        model_step(s, 8'h00, d1);
        checks++;
        if (o !== exp_out) begin
          errors++;
          $display("FAIL ctrl_change pass=%0d k=%0d: got %h expected %h", pass, k, o, exp_out);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] h, o, prev, s;
    logic [7:0]  th, di;
    reset_dut();
    for (int k = 0; k < 300; k++) begin
      s  = 16'($urandom);
      th = 8'($urandom);
      di = (k < 150) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      prev = exp_out;
      strobe(s, th, di, di, h, o);
      model_step(s, th, di);
      checks += 2;
      if (h !== prev) begin
        errors++;
        $display("FAIL random_hold k=%0d: got %h expected %h", k, h, prev);
      end
      if (o !== exp_out) begin
        errors++;
        $display("FAIL random_model k=%0d th=%h di=%h: got %h expected %h", k, th, di, o, exp_out);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] h, o, prev;
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      strobe(16'(k + 1), 8'h00, 8'd7, 8'd7, h, o);
      model_step(16'(k + 1), 8'h00, 8'd7);
    end
    checks++;
    if (signal_out !== exp_out) begin
      errors++;
      $display("FAIL midrun_pre: got %h expected %h", signal_out, exp_out);
    end
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (signal_out !== 16'd0) begin
      errors++;
      $display("FAIL midrun_async: got %h expected 0000", signal_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 12; k++) begin
      prev = exp_out;
      strobe(16'(100 + k), 8'h00, 8'd7, 8'd7, h, o);
      model_step(16'(100 + k), 8'h00, 8'd7);
      checks += 2;
      if (h !== prev) begin
        errors++;
        $display("FAIL midrun_hold k=%0d: got %h expected %h", k, h, prev);
      end
      if (o !== ((k < 7) ? 16'd0 : 16'(100 + k - 7))) begin
        errors++;
        $display("FAIL midrun_after k=%0d: got %h expected %h", k, o,
                 (k < 7) ? 16'd0 : 16'(100 + k - 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_attenuation();
    test_wrap();
    test_control_change();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
